wbu_commit: RTL

- Write-back/commit stage of the 4-stage RV32 pipeline.
- Consumes the retiring instruction from the EX/MEM stage and the load response from data memory.
- Drives the decode stage's register-file write port, CSR write port and ecall trap-write port, one registered commit pulse per instruction.
- Also produces the difftest commit strobe, commit PC and a 64-bit retired-instruction counter.

---
 rtl/wbu_commit.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wbu_commit.sv
// Write-back / commit stage of the 4-stage RV32 pipeline.
// Non-loads commit on the cycle after they are accepted. A load parks the
// stage in WAIT_LOAD until data memory returns a word. If no word arrives
// in time, the stage forces an error commit so the pipeline cannot hang.
// Every commit is a single registered pulse on the write ports and the
// difftest strobe.
module wbu_commit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [31:0]           wb_pc,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic                  wb_regwr,
    input  logic                  wb_memrd,
    input  logic [2:0]            wb_memop,
    input  logic [DATA_WIDTH-1:0] wb_aluout,
    input  logic                  wb_csrregvalid,
    input  logic                  wb_csrregwr,
    input  logic                  wb_csrset,
    input  logic [11:0]           wb_csr,
    input  logic [DATA_WIDTH-1:0] wb_csrold,
    input  logic [DATA_WIDTH-1:0] wb_rs1val,
    input  logic                  wb_ecall,
    input  logic [63:0]           wb_ecall_package,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  HoldOnRegWr,
    output logic [ADDR_WIDTH-1:0] Rw,
    output logic [DATA_WIDTH-1:0] busW,
    output logic                  CSRWren,
    output logic [11:0]           Reg_csren,
    output logic [DATA_WIDTH-1:0] CSRin,
    output logic                  ecallen,
    output logic [63:0]           ecall_packageen,
    output logic                  commit,
    output logic [31:0]           commit_pc,
    output logic                  load_err,
    output logic [63:0]           retired
);

    localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] wait_cnt;

    // Fields of the load being waited on.
    logic [31:0]           ld_pc;
    logic [ADDR_WIDTH-1:0] ld_rd;
    logic                  ld_regwr;
    logic [2:0]            ld_memop;
    logic [DATA_WIDTH-1:0] ld_aluout;
    logic                  ld_csrregvalid;
    logic                  ld_csrregwr;
    logic                  ld_csrset;
    logic [11:0]           ld_csr;
    logic [DATA_WIDTH-1:0] ld_csrold;
    logic [DATA_WIDTH-1:0] ld_rs1val;
    logic                  ld_ecall;
    logic [63:0]           ld_pkg;

    logic accept_load;
    logic commit_now;
    logic timeout;

    // The commit source is the live upstream bundle in IDLE and the parked
    // load in WAIT_LOAD.
    logic [31:0]           src_pc;
    logic [ADDR_WIDTH-1:0] src_rd;
    logic                  src_regwr;
    logic [DATA_WIDTH-1:0] src_aluout;
    logic                  src_csrregvalid;
    logic                  src_csrregwr;
    logic                  src_csrset;
    logic [11:0]           src_csr;
    logic [DATA_WIDTH-1:0] src_csrold;
    logic [DATA_WIDTH-1:0] src_rs1val;
    logic                  src_ecall;
    logic [63:0]           src_pkg;

    logic                  next_hold;
    logic [DATA_WIDTH-1:0] next_busw;
    logic [DATA_WIDTH-1:0] next_csrin;

    // Select the addressed byte or halfword of the returned word, then
    // sign- or zero-extend it. Unknown memop encodings behave as lw.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [2:0]            op,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            3'b000:  load_extend = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  load_extend = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Next-state logic, the handshake, and the decision to commit this cycle.
    always_comb begin
        state_next  = state;
        wb_ready    = 1'b0;
        accept_load = 1'b0;
        commit_now  = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    if (wb_memrd) begin
                        accept_load = 1'b1;
                        state_next  = WAIT_LOAD;
                    end else begin
                        commit_now = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    commit_now = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    commit_now = 1'b1;
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Choose the commit source and build the write-port values.
    always_comb begin
        if (state == WAIT_LOAD) begin
            src_pc          = ld_pc;
            src_rd          = ld_rd;
            src_regwr       = ld_regwr;
            src_aluout      = ld_aluout;
            src_csrregvalid = ld_csrregvalid;
            src_csrregwr    = ld_csrregwr;
            src_csrset      = ld_csrset;
            src_csr         = ld_csr;
            src_csrold      = ld_csrold;
            src_rs1val      = ld_rs1val;
            src_ecall       = ld_ecall;
            src_pkg         = ld_pkg;
            next_busw       = timeout ? '0 : load_extend(ld_memop, ld_aluout[1:0], mem_rdata);
        end else begin
            src_pc          = wb_pc;
            src_rd          = wb_rd;
            src_regwr       = wb_regwr;
            src_aluout      = wb_aluout;
            src_csrregvalid = wb_csrregvalid;
            src_csrregwr    = wb_csrregwr;
            src_csrset      = wb_csrset;
            src_csr         = wb_csr;
            src_csrold      = wb_csrold;
            src_rs1val      = wb_rs1val;
            src_ecall       = wb_ecall;
            src_pkg         = wb_ecall_package;
            next_busw       = wb_csrregvalid ? wb_csrold : wb_aluout;
        end
        // x0 is hardwired to zero; an ecall never writes a GPR.
        next_hold  = src_regwr & (src_rd != '0) & ~src_ecall;
        next_csrin = src_csrset ? (src_csrold | src_rs1val) : src_rs1val;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Count the cycles spent waiting for load data.
    always_ff @(posedge clk) begin
        if (rst || accept_load) begin
            wait_cnt <= '0;
        end else if (state == WAIT_LOAD && !commit_now) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Park the accepted load's fields for use when its data returns.
    always_ff @(posedge clk) begin
        if (accept_load) begin
            ld_pc          <= wb_pc;
            ld_rd          <= wb_rd;
            ld_regwr       <= wb_regwr;
            ld_memop       <= wb_memop;
            ld_aluout      <= wb_aluout;
            ld_csrregvalid <= wb_csrregvalid;
            ld_csrregwr    <= wb_csrregwr;
            ld_csrset      <= wb_csrset;
            ld_csr         <= wb_csr;
            ld_csrold      <= wb_csrold;
            ld_rs1val      <= wb_rs1val;
            ld_ecall       <= wb_ecall;
            ld_pkg         <= wb_ecall_package;
        end
    end

    // Registered commit pulse. Enables last one cycle; data holds until the
    // next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            HoldOnRegWr     <= 1'b0;
            Rw              <= '0;
            busW            <= '0;
            CSRWren         <= 1'b0;
            Reg_csren       <= '0;
            CSRin           <= '0;
            ecallen         <= 1'b0;
            ecall_packageen <= '0;
            commit          <= 1'b0;
            commit_pc       <= '0;
            load_err        <= 1'b0;
            retired         <= '0;
        end else begin
            HoldOnRegWr <= commit_now & next_hold;
            CSRWren     <= commit_now & src_csrregwr & ~src_ecall;
            ecallen     <= commit_now & src_ecall;
            commit      <= commit_now;
            load_err    <= commit_now & timeout;
            retired     <= retired + 64'(commit_now);
            if (commit_now) begin
                Rw              <= src_rd;
                busW            <= next_busw;
                Reg_csren       <= src_csr;
                CSRin           <= next_csrin;
                ecall_packageen <= src_pkg;
                commit_pc       <= src_pc;
            end
        end
    end

endmodule
